// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the load path (and later the store path).
// Contents:
//   SZ_*      access size encodings carried on the size port
//   LD_*      load-unit FSM state constants
//   ld_misaligned()  flags a size/lane pair that cannot be issued to memory
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] LD_IDLE = 3'd0;
  localparam logic [2:0] LD_REQ  = 3'd1;
  localparam logic [2:0] LD_DONE = 3'd2;
  localparam logic [2:0] LD_ERR  = 3'd3;
  localparam logic [2:0] LD_TOUT = 3'd4;

  // Reserved size is folded in here so the FSM has a single error test.
  function automatic logic ld_misaligned(input logic [1:0] size,
                                         input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return |lane;
      SZ_RSVD: return 1'b1;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and extension for loads.
// Ports:
//   mem_rdata  in  32  word read from memory, little-endian lanes
//   lane       in  2   byte offset within the word (addr[1:0])
//   size       in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sign_ext   in  1   1 = sign-extend, 0 = zero-extend (byte/half)
//   data       out 32  extracted, extended result
module load_extract
  import cpu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (lane)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    // Halfwords are only issued at lane 0 or 2, so lane[1] picks the half.
    lane_h = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size)
      SZ_BYTE: data = ext8(lane_b, sign_ext);
      SZ_HALF: data = ext16(lane_h, sign_ext);
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Multi-cycle load path: accepts a load request, reads one word over a
// req/ack memory handshake, extracts the addressed byte/halfword and returns
// a registered result with a one-cycle done pulse. Misaligned/reserved-size
// requests and memory timeouts complete with err and never touch the bus.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle load request (ignored while busy)
//   addr, size        byte address and access size of the load
//   sign_ext          extension mode for byte/halfword
//   busy              high from the cycle after accept through the done cycle
//   done, err         completion pulse and error flag (valid together)
//   rdata             load result, held until the next done
//   mem_req, mem_addr word read request and word-aligned address
//   mem_ack, mem_rdata memory completion and read data
module mem_load_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             sign_q;
  logic [31:0]      ext_data;

  load_extract u_extract (
    .mem_rdata (mem_rdata),
    .lane      (lane_q),
    .size      (size_q),
    .sign_ext  (sign_q),
    .data      (ext_data)
  );

  // Request attributes only matter once REQ is reached, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == LD_IDLE && start) begin
      lane_q <= addr[1:0];
      size_q <= size;
      sign_q <= sign_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LD_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        LD_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (ld_misaligned(size, addr[1:0])) begin
              state <= LD_ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state    <= LD_REQ;
              mem_req  <= 1'b1;
              mem_addr <= {addr[31:2], 2'b00};
              cnt      <= '0;
            end
          end
        end
        LD_REQ: begin
          // Ack is tested first so a late ack on the last cycle still completes.
          if (mem_ack) begin
            rdata   <= ext_data;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= LD_DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= LD_TOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // DONE / ERR / TOUT: the completion cycle; start is dropped here.
        default: begin
          busy  <= 1'b0;
          state <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
Multi-cycle CPU load path: the read side that feeds the buffer registers. It takes a load request from the control FSM, performs a word read on the data-memory bus with a req/ack handshake, and extracts the addressed byte or halfword. It returns a registered, sign- or zero-extended 32-bit result with a one-cycle done pulse. Misaligned accesses and memory timeouts are reported and never reach the memory bus.

Parameters:
TIMEOUT, 16, number of cycles in REQ without mem_ack before the access is aborted with err (must be ≥1)
CNT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle load request; ignored while busy=1
addr  in  32  byte address of the load
size  in  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as err)
sign_ext  in  1  1=sign-extend, 0=zero-extend (byte/halfword only)
busy  out  1  high from the cycle after an accepted start until the cycle done is high, inclusive
done  out  1  one-cycle pulse; rdata/err valid in the same cycle
err  out  1  valid with done: misalignment, reserved size, or timeout
rdata  out  32  extracted load result; holds its value until the next done
mem_req  out  1  read request to data memory
mem_addr  out  32  word address {addr[31:2],2'b00}, stable while mem_req=1
mem_ack  in  1  memory read complete; mem_rdata valid this cycle
mem_rdata  in  32  memory read word, little-endian lanes

Behaviour:
- Reset (async): state=IDLE; busy, done, err, mem_req = 0; rdata = 0; mem_addr = 0; counter = 0. Reset mid-access drops mem_req immediately and emits no done.
- Registered outputs only; no combinational path from inputs to outputs.
- States:
  - IDLE: start latches addr, size, sign_ext.
    - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=11 -> ERR.
    - Otherwise -> REQ.
  - REQ: mem_req=1, mem_addr held, counter increments each cycle.
    - mem_ack -> capture/extract into rdata -> DONE.
    - counter reaches TIMEOUT-1 without ack -> TOUT.
  - DONE: done=1, err=0, mem_req=0 -> IDLE.
  - ERR / TOUT: done=1, err=1, rdata unchanged, mem_req=0 -> IDLE.
- Latency: start at cycle 0 -> mem_req high at cycle 1. mem_ack at cycle k (k≥1) -> done at cycle k+1. Minimum 2 cycles from start to done. Error path: done at cycle 1.
- Extraction lane = latched addr[1:0]:
  - byte: mem_rdata[8*lane+7 : 8*lane].
  - half: lane 0 -> [15:0], lane 2 -> [31:16].
  - Extend per sign_ext. Word: unchanged.
- mem_ack outside REQ is ignored. mem_ack in the same cycle as timeout expiry: ack wins.
- start while busy (REQ/DONE/ERR/TOUT) is dropped, not queued. start in the done cycle is also dropped. Back-to-back accesses accept start the cycle after done.
- Counter clears on entry to REQ.

Decomposition:
- Shared package cpu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum LD_IDLE/LD_REQ/LD_DONE/LD_ERR/LD_TOUT.
- One sub-module: load_extract (combinational lane select + extension: mem_rdata, lane, size, sign_ext -> 32-bit). Reused later by the store-merge path's inverse.

Test Plan:
- Word load: start, addr=0x100, size=10; mem_ack at cycle 3 with mem_rdata=0xDEADBEEF -> mem_addr=0x100 cycles 1–3, done at cycle 4, rdata=0xDEADBEEF, err=0.
- Byte sign/zero: addr=0x103, size=00, mem_rdata=0x80FF1234 -> sign_ext=1 gives rdata=0xFFFFFF80; sign_ext=0 gives 0x00000080.
- Halfword upper: addr=0x202, size=01, sign_ext=1, mem_rdata=0x8001ABCD -> rdata=0xFFFF8001. Misaligned addr=0x201 -> done at cycle 1, err=1, mem_req never asserted, rdata unchanged.
- Timeout with TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then done=1, err=1. Ack on the 4th REQ cycle -> normal done, err=0.
- start pulsed during REQ with a different addr -> ignored, mem_addr unchanged. Spurious mem_ack in IDLE -> no done.
- rst asserted in the middle of REQ -> mem_req, busy and rdata go to 0 the same cycle. After release, a new load completes normally.
